char_rom_arbiter: RTL and testbench
===================================

Name: char_rom_arbiter

Overview:
- Shares the single synchronous character ROM port between several text-field generators (lag digits, min/max/avg counters, resolution text) that each need glyph-row lookups during the horizontal blanking window.
- Accepts per-requester address requests, grants one per cycle (round-robin, with optional burst lock), and drives the ROM address.
- Returns the ROM data tagged to the originating requester with fixed latency.
- Sits between the text line builders and char_rom.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- ADDR_W, 8, ROM address width
- DATA_W, 8, ROM data width (one glyph row)
- ROM_LAT, 1, cycles from rom_addr change to valid rom_q (1..3)

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  line-start pulse; drops in-flight reads, resets arbitration
- req  in  NUM_REQ  per-requester read request, held until granted
- lock  in  NUM_REQ  per-requester burst lock, meaningful only with req
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, slice i belongs to requester i
- gnt  out  NUM_REQ  one-hot combinational grant
- rom_addr  out  ADDR_W  registered address to char_rom
- rom_q  in  DATA_W  char_rom read data
- rsp_valid  out  NUM_REQ  one-hot registered response strobe
- rsp_data  out  DATA_W  registered glyph row

Behaviour:
- Reset (async, reset_n low):
  - rom_addr=0, rsp_valid=0, rsp_data=0.
  - Tag pipeline cleared.
  - rr_last=NUM_REQ-1, so port 0 wins first.
  - owner_valid=0.
- Grant rules:
  - gnt is combinational from req, rr_last and owner state.
  - Priority order when unlocked: rr_last+1, rr_last+2 … wrapping modulo NUM_REQ.
  - At most one gnt bit per cycle; gnt=0 when req=0 or flush=1.
  - A transfer occurs at a clock edge where req[i]&gnt[i]; requester drops or updates req/req_addr after that edge.
  - req_addr must be stable while req is high and not granted.
- Round-robin:
  - rr_last <= i on every transfer.
  - No update on cycles without a transfer.
- Lock (burst):
  - A transfer with lock[i]=1 sets owner=i, owner_valid=1.
  - While owner_valid, only the owner can be granted. Other requesters wait even if the owner's req is low for a cycle.
  - owner_valid clears on an owner transfer with lock=0, on flush, or on reset.
- ROM side:
  - On a transfer, rom_addr <= req_addr[i] at the same edge.
  - rom_addr holds its value when idle.
- Tag pipeline:
  - Depth ROM_LAT+1; each stage is {valid, id[clog2(NUM_REQ)]}.
  - The stage-0 entry is written at the transfer edge.
- Response:
  - rsp_data <= rom_q and rsp_valid <= onehot(id) when the final stage is valid; otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: transfer at edge E → rom_addr valid after E → rsp_valid high for exactly one cycle after edge E+ROM_LAT+1. ROM_LAT=1 gives 2 edges.
- Throughput: one transfer per cycle, back-to-back allowed, including the same requester under lock.
- Flush:
  - Synchronous; clears all tag valids (pending responses never appear), clears owner_valid, sets rr_last=NUM_REQ-1.
  - No grant in the flush cycle.
  - rom_addr unchanged.
- Flush coincident with the final-stage response: that response is dropped.

Optional Feature:
- Macro: CHAR_ROM_ARB_FIXED_PRIO_EN.
- Defined: strict fixed priority, lowest index wins. rr_last is unused and held at reset value. Lock still honoured.
- Undefined: round-robin as above.

Decomposition:
- Shared package / defines.v:
  - CHAR_ROM_ADDR_W, CHAR_ROM_DATA_W
  - requester index constants REQ_LAG, REQ_MIN, REQ_MAX, REQ_AVG
  - typedef for the tag struct {valid, id}
- Sub-module: rr_pick (combinational rotate-priority one-hot picker, inputs req mask and rr_last). Reused by the fixed-priority build with rr_last tied to NUM_REQ-1.

Test Plan:
- Single request: req=0001, addr 0x35 → gnt=0001 same cycle; rom_addr=0x35 next cycle; rsp_valid=0001 with rom_q data 2 edges after transfer (ROM_LAT=1).
- All four requesting continuously, no lock → grants cycle 0,1,2,3,0,…; each port gets exactly 25 grants in 100 cycles; responses arrive in grant order.
- Port 2 lock for 5 transfers (lock low on the 5th) while ports 0,1,3 request → five consecutive gnt=0100, then port 3 granted next.
- Flush one cycle after two transfers in flight → no rsp_valid pulses; next grant goes to port 0 regardless of prior rr_last.
- reset_n asserted mid-burst (async, between edges) → rsp_valid, rom_addr, rsp_data go 0 immediately; after release, first grant goes to port 0.
- CHAR_ROM_ARB_FIXED_PRIO_EN defined, req=1010 held → port 1 granted every cycle; port 3 never granted until req[1] drops.

Source files
------------

// File: rtl/char_rom_arbiter_pkg.sv
// Shared constants and response-tag type for the character ROM arbiter.
package char_rom_arbiter_pkg;

  localparam int CHAR_ROM_ADDR_W = 8;
  localparam int CHAR_ROM_DATA_W = 8;

  localparam int REQ_LAG = 0;
  localparam int REQ_MIN = 1;
  localparam int REQ_MAX = 2;
  localparam int REQ_AVG = 3;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/char_rom_arbiter_rr_pick.sv
// Rotating-priority one-hot picker: searches from last_i+1 upward, wrapping.
module char_rom_arbiter_rr_pick
  import char_rom_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/char_rom_arbiter.sv
// Shares one synchronous char ROM port between text-field generators, returning tagged data.
// Define CHAR_ROM_ARB_FIXED_PRIO_EN for strict lowest-index-first priority instead of round-robin.
module char_rom_arbiter
  import char_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = CHAR_ROM_ADDR_W,
  parameter int DATA_W  = CHAR_ROM_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         rom_q_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
`ifdef CHAR_ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic [IDX_W-1:0]   rr_last_q, owner_q, pick_idx, pick_last;
  logic               owner_valid_q, xfer;
  logic [NUM_REQ-1:0] elig, pick_gnt;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  tag_t               tag_q [ROM_LAT+1];
  tag_t               tag_fin;

  // A burst owner masks everyone else, even on cycles where it is not requesting.
  always_comb begin
    elig = req_i;
    if (owner_valid_q) elig = req_i & (NUM_REQ'(1) << owner_q);
    if (flush_i) elig = '0;
  end

  assign pick_last = FIXED_PRIO ? LAST_RST : rr_last_q;

  char_rom_arbiter_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (elig),
    .last_i (pick_last),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign gnt_o   = pick_gnt;
  assign xfer    = |pick_gnt;
  assign tag_fin = tag_q[ROM_LAT];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rom_addr_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rr_last_q     <= LAST_RST;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else if (flush_i) begin
      // The response due at this edge is dropped along with everything in flight.
      rsp_valid_q   <= '0;
      rr_last_q     <= LAST_RST;
      owner_valid_q <= 1'b0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      for (int k = ROM_LAT; k > 0; k--) tag_q[k] <= tag_q[k-1];
      tag_q[0].valid <= xfer;
      tag_q[0].id    <= TAG_ID_W'(pick_idx);

      if (tag_fin.valid) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_fin.id;
        rsp_data_q  <= rom_q_i;
      end else begin
        rsp_valid_q <= '0;
      end

      if (xfer) begin
        rom_addr_q    <= req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
        owner_q       <= pick_idx;
        owner_valid_q <= lock_i[pick_idx];
        if (!FIXED_PRIO) rr_last_q <= pick_idx;
      end
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Randomized scoreboard bench for char_rom_arbiter against a queue-based reference model.
module tb_char_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req = '0, lock = '0, gnt, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_q = '0, rsp_data;
  logic [DW-1:0]   rom_mem [256];

  char_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .flush_i     (flush),
    .req_i       (req),
    .lock_i      (lock),
    .req_addr_i  (req_addr),
    .gnt_o       (gnt),
    .rom_addr_o  (rom_addr),
    .rom_q_i     (rom_q),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          port;
    logic [7:0]  data;
    int          due;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         glog[$];
  int         checks = 0, errors = 0, pulses = 0;
  int         m_rr, m_owner, mode, lock_left;
  logic [7:0] m_rom_addr;
  bit         p_req [N];
  bit         p_lock [N];
  logic [7:0] p_addr [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Reference arbitration: owner exclusive, else first requester after the last winner.
  function automatic int model_pick(input bit fl);
    int base;
`ifdef CHAR_ROM_ARB_FIXED_PRIO_EN
    base = N - 1;
`else
    base = m_rr;
`endif
    if (fl) return -1;
    if (m_owner >= 0) return p_req[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++)
      if (p_req[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic after_xfer(input int w);
    case (mode)
      0: begin
        p_req[w]  = bit'($urandom_range(0, 1));
        p_addr[w] = 8'($urandom);
        p_lock[w] = ($urandom_range(0, 2) == 0);
      end
      1: begin
        p_addr[w] = 8'($urandom);
        p_lock[w] = 1'b0;
      end
      2: begin
        p_addr[w] = 8'($urandom);
        if (w == 2) begin
          lock_left--;
          p_lock[2] = (lock_left > 1);
          if (lock_left == 0) p_req[2] = 1'b0;
        end
      end
      default: p_req[w] = 1'b0;
    endcase
  endtask

  task automatic idle_update();
    if (mode == 0)
      for (int i = 0; i < N; i++)
        if (!p_req[i] && $urandom_range(0, 1) == 1) begin
          p_req[i]  = 1'b1;
          p_addr[i] = 8'($urandom);
          p_lock[i] = ($urandom_range(0, 2) == 0);
        end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic do_cycle(input bit fl);
    int   w, e;
    exp_t keep[$];
    flush = fl;
    for (int i = 0; i < N; i++) begin
      req[i]               = p_req[i];
      lock[i]              = p_req[i] & p_lock[i];
      req_addr[i*AW +: AW] = p_addr[i];
    end
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    w = model_pick(fl);
    chk("gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
    glog.push_back(onehot_idx(gnt));
    e = edge_n + 1;
    if (fl) begin
      foreach (sb[k]) if (sb[k].due < e) keep.push_back(sb[k]);
      sb      = keep;
      m_owner = -1;
      m_rr    = N - 1;
    end else if (w >= 0) begin
      sb.push_back('{w, rom_mem[p_addr[w]], e + LAT + 1});
      m_rom_addr = p_addr[w];
      m_rr       = w;
      m_owner    = p_lock[w] ? w : -1;
      after_xfer(w);
    end
    idle_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_all(input bit r);
    for (int i = 0; i < N; i++) begin
      p_req[i]  = r;
      p_lock[i] = 1'b0;
      p_addr[i] = 8'($urandom);
    end
  endtask

  task automatic drain();
    mode = 3;
    set_all(1'b0);
    do_cycle(1'b1);
    repeat (4) do_cycle(1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid != '0) begin
        pulses++;
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'd1 << mon_e.port);
          chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
          chk("rsp_edge", 32'(edge_n), 32'(mon_e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= edge_n) begin
        mon_e = sb.pop_front();
        chk("rsp_missing", 32'(rsp_valid), 32'd1 << mon_e.port);
      end
    end
  end

  initial begin
    int s, p, cnt[N];
    for (int a = 0; a < 256; a++) rom_mem[a] = 8'($urandom);
    m_rr = N - 1; m_owner = -1; m_rom_addr = '0; mode = 0; lock_left = 0;
    set_all(1'b0);
    #2;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with random locks and occasional flushes.
    mode = 0;
    repeat (300) do_cycle($urandom_range(0, 29) == 0);
    drain();

    // Continuous requests from all ports, no lock.
    mode = 1;
    set_all(1'b1);
    do_cycle(1'b1);
    s = glog.size();
    repeat (100) do_cycle(1'b0);
`ifndef CHAR_ROM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = s; k < s + 100; k++) if (glog[k] >= 0) cnt[glog[k]]++;
    for (int i = 0; i < N; i++) chk("rr_share", 32'(cnt[i]), 32'd25);
`endif
    drain();

    // Port 2 burst of five transfers while others keep requesting.
    mode = 2;
    set_all(1'b1);
    p_lock[2] = 1'b1;
    lock_left = 5;
    do_cycle(1'b1);
    s = glog.size();
    repeat (10) do_cycle(1'b0);
`ifndef CHAR_ROM_ARB_FIXED_PRIO_EN
    chk("lock_seq0", 32'(glog[s]), 32'd0);
    chk("lock_seq1", 32'(glog[s+1]), 32'd1);
    for (int k = 2; k < 7; k++) chk("lock_burst", 32'(glog[s+k]), 32'd2);
    chk("lock_after", 32'(glog[s+7]), 32'd3);
`endif
    drain();

    // Flush with two reads in flight: neither response may appear.
    mode = 3;
    p_req[1] = 1'b1; p_req[2] = 1'b1;
    do_cycle(1'b0);
    do_cycle(1'b0);
    p = pulses;
    do_cycle(1'b1);
    set_all(1'b1);
    do_cycle(1'b0);
    chk("flush_next_gnt", 32'(glog[glog.size()-1]), 32'd0);
    do_cycle(1'b0);
    #1;
    chk("flush_drop", 32'(pulses), 32'(p));
    drain();

    // Asynchronous reset in the middle of a burst.
    mode = 1;
    set_all(1'b1);
    do_cycle(1'b1);
    repeat (6) do_cycle(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("areset_rom_addr", 32'(rom_addr), 32'd0);
    chk("areset_rsp_data", 32'(rsp_data), 32'd0);
    sb.delete();
    m_rr = N - 1; m_owner = -1; m_rom_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b0);
    chk("areset_first_gnt", 32'(glog[glog.size()-1]), 32'd0);
    repeat (8) do_cycle(1'b0);
    drain();

`ifdef CHAR_ROM_ARB_FIXED_PRIO_EN
    mode = 1;
    set_all(1'b0);
    p_req[1] = 1'b1; p_req[3] = 1'b1;
    s = glog.size();
    repeat (20) do_cycle(1'b0);
    for (int k = s; k < s + 20; k++) chk("fixed_port1", 32'(glog[k]), 32'd1);
    p_req[1] = 1'b0;
    do_cycle(1'b0);
    chk("fixed_port3", 32'(glog[glog.size()-1]), 32'd3);
    drain();
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
